pc_stack: RTL and testbench



---
 rtl/pc_stack_pkg.sv | 19 +
 rtl/pc_stack_lifo_stack.sv | 59 +++++
 rtl/pc_stack.sv | 95 +++++++++
 tb/tb_pc_stack.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_stack_pkg.sv
// Shared definitions for the program-counter / call-stack block:
// the per-cycle action encoding and the depth-counter width helper.
package pc_stack_pkg;

    typedef enum logic [2:0] {
        ACT_HOLD  = 3'd0,
        ACT_INC   = 3'd1,
        ACT_LOAD  = 3'd2,
        ACT_CALL  = 3'd3,
        ACT_RET   = 3'd4,
        ACT_RESET = 3'd5
    } action_t;

    // Bits needed to count 0..entries inclusive.
    function automatic int depth_bits(input int entries);
        return $clog2(entries + 1);
    endfunction

endpackage

// File: rtl/pc_stack_lifo_stack.sv
// Register-array LIFO holding return addresses. Only the pointer is reset;
// pushes while full and pops while empty are refused.
module lifo_stack
    import pc_stack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              wdata,
    output logic [WIDTH-1:0]              rdata,
    output logic [depth_bits(DEPTH)-1:0]  depth,
    output logic                          full,
    output logic                          empty
);

    localparam int DW = depth_bits(DEPTH);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DW-1:0]    ptr;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (ptr == DW'(DEPTH));
    assign empty   = (ptr == '0);
    assign depth   = ptr;
    assign wr_idx  = IW'(ptr);
    assign rd_idx  = IW'(ptr - DW'(1));

    // Pop wins if both are requested; the top level never asks for both.
    assign do_pop  = pop && !empty;
    assign do_push = push && !full && !do_pop;

    assign rdata   = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (do_pop) begin
            ptr <= ptr - DW'(1);
        end else if (do_push) begin
            ptr <= ptr + DW'(1);
        end
    end

    // Storage carries no reset; stale entries above the pointer are never read.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_stack.sv
// Program counter with hardware call/return stack. One action per cycle,
// chosen by priority reset > ret > call > load > inc > hold.
module pc_stack
    import pc_stack_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter int               DEPTH      = 8,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic                          inc,
    input  logic                          call,
    input  logic                          ret,
    input  logic [WIDTH-1:0]              in,
    output logic [WIDTH-1:0]              out,
    output logic [depth_bits(DEPTH)-1:0]  depth,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow,
    output logic                          underflow
);

    action_t          action;
    logic [WIDTH-1:0] next_seq;
    logic [WIDTH-1:0] top_addr;
    logic             push;
    logic             pop;

    always_comb begin
        action = ACT_HOLD;
        if (reset) begin
            action = ACT_RESET;
        end else if (ret) begin
            action = ACT_RET;
        end else if (call) begin
            action = ACT_CALL;
        end else if (load) begin
            action = ACT_LOAD;
        end else if (inc) begin
            action = ACT_INC;
        end
    end

    // Return address and increment share one adder; wraps silently.
    assign next_seq = out + 1'b1;

    assign push = (action == ACT_CALL) && !full;
    assign pop  = (action == ACT_RET) && !empty;

    lifo_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (next_seq),
        .rdata (top_addr),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    // A refused call or ret only raises its sticky flag; out is untouched.
    always_ff @(posedge clk) begin
        case (action)
            ACT_RESET: begin
                out       <= RESET_ADDR;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            ACT_RET: begin
                if (empty) begin
                    underflow <= 1'b1;
                end else begin
                    out <= top_addr;
                end
            end
            ACT_CALL: begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    out <= in;
                end
            end
            ACT_LOAD: out <= in;
            ACT_INC:  out <= next_seq;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed vector table, corner-case
// sequences, and random traffic compared against a queue-based model.
module tb_pc_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int DW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset, load, inc, call, ret;
    logic [WIDTH-1:0]  in;
    logic [WIDTH-1:0]  out;
    logic [DW-1:0]     depth;
    logic              full, empty, overflow, underflow;

    always #5 clk = ~clk;

    pc_stack #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .RESET_ADDR (16'h0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .inc       (inc),
        .call      (call),
        .ret       (ret),
        .in        (in),
        .out       (out),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Reference model: a queue is the call stack, pushed at the back.
    logic [WIDTH-1:0] m_out;
    logic [WIDTH-1:0] m_stack [$];
    bit               m_ovf;
    bit               m_unf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit               r, rt, c, l, i;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] exp_out;
        int               exp_depth;
        bit               exp_ovf;
        bit               exp_unf;
    } vec_t;

    vec_t vecs[$];

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name);
        int sz;
        sz = m_stack.size();
        checkValue({name, ".out"},       32'(out),       32'(m_out));
        checkValue({name, ".depth"},     32'(depth),     32'(sz));
        checkValue({name, ".full"},      32'(full),      32'(sz == DEPTH));
        checkValue({name, ".empty"},     32'(empty),     32'(sz == 0));
        checkValue({name, ".overflow"},  32'(overflow),  32'(m_ovf));
        checkValue({name, ".underflow"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic modelStep(input bit r, input bit rt, input bit c, input bit l, input bit i,
                             input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] nxt;
        nxt = m_out + 16'd1;
        if (r) begin
            m_out = 16'h0000;
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (rt) begin
            if (m_stack.size() > 0) m_out = m_stack.pop_back();
            else                    m_unf = 1'b1;
        end else if (c) begin
            if (m_stack.size() < DEPTH) begin
                m_stack.push_back(nxt);
                m_out = d;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (l) begin
            m_out = d;
        end else if (i) begin
            m_out = nxt;
        end
    endtask

    // Drive one cycle of commands, advance the model, sample 1 time unit after the edge.
    task automatic applyStimulus(input bit r, input bit rt, input bit c, input bit l, input bit i,
                                 input logic [WIDTH-1:0] d);
        reset = r; ret = rt; call = c; load = l; inc = i; in = d;
        @(posedge clk);
        modelStep(r, rt, c, l, i, d);
        #1;
        reset = 0; ret = 0; call = 0; load = 0; inc = 0;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1; ret = 0; call = 0; load = 0; inc = 0; in = '0;
        m_out = '0; m_ovf = 0; m_unf = 0;

        // r rt c l i data | out depth ovf unf
        vecs.push_back('{1,0,0,0,0,16'h0000, 16'h0000, 0, 0, 0});
        vecs.push_back('{0,0,0,0,1,16'h0000, 16'h0001, 0, 0, 0});
        vecs.push_back('{0,0,0,0,1,16'h0000, 16'h0002, 0, 0, 0});
        vecs.push_back('{0,0,0,0,1,16'h0000, 16'h0003, 0, 0, 0});
        vecs.push_back('{0,0,0,1,0,16'hFFFF, 16'hFFFF, 0, 0, 0});
        vecs.push_back('{0,0,0,0,1,16'h0000, 16'h0000, 0, 0, 0});
        vecs.push_back('{0,0,0,1,0,16'h0010, 16'h0010, 0, 0, 0});
        vecs.push_back('{0,0,1,0,0,16'h0200, 16'h0200, 1, 0, 0});
        vecs.push_back('{0,0,1,0,0,16'h0300, 16'h0300, 2, 0, 0});
        vecs.push_back('{0,1,0,0,0,16'h0000, 16'h0201, 1, 0, 0});
        vecs.push_back('{0,1,0,0,0,16'h0000, 16'h0011, 0, 0, 0});
        vecs.push_back('{0,0,0,0,0,16'h1234, 16'h0011, 0, 0, 0});
        vecs.push_back('{0,0,0,1,1,16'h0500, 16'h0500, 0, 0, 0});
        vecs.push_back('{0,0,0,1,0,16'hFFFF, 16'hFFFF, 0, 0, 0});
        vecs.push_back('{0,0,1,0,0,16'h0700, 16'h0700, 1, 0, 0});
        vecs.push_back('{0,1,0,0,0,16'h0000, 16'h0000, 0, 0, 0});

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].r, vecs[k].rt, vecs[k].c, vecs[k].l, vecs[k].i, vecs[k].d);
            checkValue($sformatf("vec%0d.out", k),       32'(out),       32'(vecs[k].exp_out));
            checkValue($sformatf("vec%0d.depth", k),     32'(depth),     32'(vecs[k].exp_depth));
            checkValue($sformatf("vec%0d.overflow", k),  32'(overflow),  32'(vecs[k].exp_ovf));
            checkValue($sformatf("vec%0d.underflow", k), 32'(underflow), 32'(vecs[k].exp_unf));
            checkOutput($sformatf("vec%0d", k));
        end

        // Fill to capacity, then one more call must only raise overflow.
        applyStimulus(1,0,0,0,0,16'h0000);
        applyStimulus(0,0,0,1,0,16'h0100);
        for (int k = 0; k < 9; k++) begin
            applyStimulus(0,0,1,0,0,16'(16'h1000 + k * 16'h0010));
            checkOutput($sformatf("fill%0d", k));
        end
        checkValue("fill.out",      32'(out),      32'h1070);
        checkValue("fill.depth",    32'(depth),    32'd8);
        checkValue("fill.full",     32'(full),     32'd1);
        checkValue("fill.overflow", 32'(overflow), 32'd1);

        for (int k = 0; k < 9; k++) begin
            applyStimulus(0,1,0,0,0,16'h0000);
            checkOutput($sformatf("drain%0d", k));
            if (k == 0) checkValue("drain.first", 32'(out), 32'h1061);
            if (k == 7) checkValue("drain.last",  32'(out), 32'h0101);
        end
        checkValue("drain.out",       32'(out),       32'h0101);
        checkValue("drain.underflow", 32'(underflow), 32'd1);
        checkValue("drain.empty",     32'(empty),     32'd1);

        // Reset alongside call+load at depth 3 must have no partial effect.
        applyStimulus(0,0,1,0,0,16'h0A00);
        applyStimulus(0,0,1,0,0,16'h0B00);
        applyStimulus(0,0,1,0,0,16'h0C00);
        checkValue("mid.depth", 32'(depth), 32'd3);
        applyStimulus(1,0,1,1,0,16'h0D00);
        checkValue("rstcall.out",       32'(out),       32'h0000);
        checkValue("rstcall.depth",     32'(depth),     32'd0);
        checkValue("rstcall.overflow",  32'(overflow),  32'd0);
        checkValue("rstcall.underflow", 32'(underflow), 32'd0);
        checkOutput("rstcall");

        // ret + call + inc together with top = 0x0042: only the return happens.
        applyStimulus(0,0,0,1,0,16'h0041);
        applyStimulus(0,0,1,0,0,16'h0900);
        applyStimulus(0,1,1,0,1,16'h0777);
        checkValue("retcall.out",   32'(out),   32'h0042);
        checkValue("retcall.depth", 32'(depth), 32'd0);
        checkOutput("retcall");

        // Random traffic, biased so overflow, underflow and resets all occur.
        for (int k = 0; k < 3000; k++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 1) == 0,
                          16'($urandom));
            checkOutput($sformatf("rand%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
